// File: rtl/heart_pattern_decoder_if.sv
// Pixel-column input lines and frame-check status bundle for heart_pattern_decoder.
// The source side drives the twelve signal lines; the decoder drives all status outputs.
// No handshake: one column is presented per clock and consumed unconditionally.
interface heart_pattern_decoder_if #(
  parameter int CNT_W = 16
);
  logic             signal1, signal2, signal3, signal4, signal5, signal6;
  logic             signal7, signal8, signal9, signal10, signal11, signal12;
  logic             frame_done;
  logic             frame_ok;
  logic [3:0]       mismatch_cols;
  logic             trail_err;
  logic             locked;
  logic             busy;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;

  modport master (
    output signal1, signal2, signal3, signal4, signal5, signal6,
           signal7, signal8, signal9, signal10, signal11, signal12,
    input  frame_done, frame_ok, mismatch_cols, trail_err, locked, busy,
           good_cnt, bad_cnt
  );

  modport slave (
    input  signal1, signal2, signal3, signal4, signal5, signal6,
           signal7, signal8, signal9, signal10, signal11, signal12,
    output frame_done, frame_ok, mismatch_cols, trail_err, locked, busy,
           good_cnt, bad_cnt
  );
endinterface

// File: rtl/heart_pattern_decoder.sv
// Frames a 12-bit column stream on blank gaps and checks each 13-column frame against the heart bitmap.
// Latency: verdict, counters and frame_done update 14 edges after frame column 0 is sampled.
// No backpressure: one column is consumed every clock; all outputs are registered.
module heart_pattern_decoder #(
  parameter int GAP_MIN = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  heart_pattern_decoder_if.slave bus
);

  typedef enum logic [1:0] {SEEK, ARMED, CAPTURE, TRAIL} state_e;

  localparam logic [3:0]       GAP_SAT = 4'(GAP_MIN);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [11:0] heart_col(input logic [3:0] i);
    case (i)
      4'd0:    heart_col = 12'h01C;
      4'd1:    heart_col = 12'h03E;
      4'd2:    heart_col = 12'h07F;
      4'd3:    heart_col = 12'h0FF;
      4'd4:    heart_col = 12'h1FE;
      4'd5:    heart_col = 12'h3FC;
      4'd6:    heart_col = 12'hFF8;
      4'd7:    heart_col = 12'h3FC;
      4'd8:    heart_col = 12'h1FE;
      4'd9:    heart_col = 12'h0FF;
      4'd10:   heart_col = 12'h07F;
      4'd11:   heart_col = 12'h03E;
      4'd12:   heart_col = 12'h01C;
      default: heart_col = 12'h000;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [11:0]      col_q, col_d;
  logic             col_vld_q, col_vld_d;
  logic [3:0]       gap_q, gap_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       mis_q, mis_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic [3:0]       mcols_q, mcols_d;
  logic             trail_q, trail_d;
  logic             locked_q, locked_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;

  logic             col_zero, col_hit, frame_good;
  logic [3:0]       gap_inc;

  // Next-state: input capture, framing FSM, verdict and counter updates.
  always_comb begin
    col_d     = {bus.signal12, bus.signal11, bus.signal10, bus.signal9,
                 bus.signal8,  bus.signal7,  bus.signal6,  bus.signal5,
                 bus.signal4,  bus.signal3,  bus.signal2,  bus.signal1};
    col_vld_d = 1'b1;
    state_d   = state_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    mis_d     = mis_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    mcols_d   = mcols_q;
    trail_d   = trail_q;
    locked_d  = locked_q;
    good_d    = good_q;
    bad_d     = bad_q;

    col_zero   = (col_q == 12'h000);
    col_hit    = (col_q == heart_col(idx_q));
    frame_good = (mis_q == 4'd0) && col_zero;
    gap_inc    = (gap_q < GAP_SAT) ? gap_q + 4'd1 : gap_q;

    // col_q holds the reset value, not a sampled column, until the first edge after release.
    if (col_vld_q) begin
      unique case (state_q)
        SEEK: begin
          if (col_zero) begin
            gap_d = gap_inc;
            if (gap_inc == GAP_SAT) state_d = ARMED;
          end else begin
            gap_d = 4'd0;
          end
        end
        ARMED: begin
          if (!col_zero) begin
            mis_d   = {3'b000, !col_hit};
            idx_d   = 4'd1;
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (!col_hit) mis_d = mis_q + 4'd1;
          if (idx_q == 4'd12) begin
            idx_d   = 4'd0;
            state_d = TRAIL;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        TRAIL: begin
          done_d   = 1'b1;
          ok_d     = frame_good;
          mcols_d  = mis_q;
          trail_d  = !col_zero;
          locked_d = frame_good;
          if (frame_good) begin
            if (good_q != {CNT_W{1'b1}}) good_d = good_q + CNT_ONE;
          end else begin
            if (bad_q != {CNT_W{1'b1}}) bad_d = bad_q + CNT_ONE;
          end
          // A blank trailing column already counts as one gap column.
          gap_d   = col_zero ? 4'd1 : 4'd0;
          state_d = (col_zero && GAP_SAT == 4'd1) ? ARMED : SEEK;
        end
        default: state_d = SEEK;
      endcase
    end

    busy_d = (state_d == CAPTURE) || (state_d == TRAIL);
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEEK;
      col_q     <= 12'h000;
      col_vld_q <= 1'b0;
      gap_q     <= 4'd0;
      idx_q     <= 4'd0;
      mis_q     <= 4'd0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      mcols_q   <= 4'd0;
      trail_q   <= 1'b0;
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
      good_q    <= '0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      col_vld_q <= col_vld_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      mis_q     <= mis_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      mcols_q   <= mcols_d;
      trail_q   <= trail_d;
      locked_q  <= locked_d;
      busy_q    <= busy_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
    end
  end

  assign bus.frame_done    = done_q;
  assign bus.frame_ok      = ok_q;
  assign bus.mismatch_cols = mcols_q;
  assign bus.trail_err     = trail_q;
  assign bus.locked        = locked_q;
  assign bus.busy          = busy_q;
  assign bus.good_cnt      = good_q;
  assign bus.bad_cnt       = bad_q;

endmodule
